// File: rtl/wordle_guess_scorer_if.sv
// Request/result bundle between the game state machine and the guess scorer.
//   start  : request scoring of guess against answer (sampled only when idle)
//   guess  : NUM_LETTERS letters of LETTER_W bits, letter 0 in the MSBs
//   answer : word of the day, same packing as guess
//   busy   : scorer is not idle
//   done   : one-cycle pulse, score/win/err valid
//   score  : 2 bits per letter (00 gray, 01 yellow, 10 green), letter 0 in the MSBs
//   win    : every letter green
//   err    : guess held a letter outside 'A'..'Z' (letter-check builds only)
// master = game state machine side, slave = scorer side.
interface wordle_guess_scorer_if #(
  parameter int NUM_LETTERS = 5,
  parameter int LETTER_W    = 8
);
  logic                            start;
  logic [NUM_LETTERS*LETTER_W-1:0] guess;
  logic [NUM_LETTERS*LETTER_W-1:0] answer;
  logic                            busy;
  logic                            done;
  logic [2*NUM_LETTERS-1:0]        score;
  logic                            win;
  logic                            err;

  modport master (
    output start, guess, answer,
    input  busy, done, score, win, err
  );

  modport slave (
    input  start, guess, answer,
    output busy, done, score, win, err
  );
endinterface

// File: rtl/wordle_guess_scorer.sv
// Sequenced Wordle scoring engine for one guess against the word of the day.
// A green pass (exact position) runs first, one letter per cycle, then a
// yellow pass that matches each non-green guess letter against the lowest
// still-unused answer letter, so duplicate letters are never over-credited.
// Both passes share one comparator bank indexed by idx.
//
// Ports:
//   Clk   : system clock, all logic on posedge
//   reset : synchronous, active-high; aborts any scoring in progress
//   bus   : wordle_guess_scorer_if slave modport (start/guess/answer in,
//           busy/done/score/win/err out)
//
// Latency: start sampled on edge E0, done high in the cycle after E0+10,
// busy high for 11 cycles. start while busy is dropped.
//
// Build option: define WORDLE_SCORE_LETTER_CHECK_EN to range-check guess
// letters ('A'..'Z') at capture; an out-of-range letter reports err=1 with
// score and win forced to 0. Without it err is tied 0 and bytes are scored
// as-is.
module wordle_guess_scorer #(
  parameter int NUM_LETTERS = 5,
  parameter int LETTER_W    = 8
) (
  input  logic                  Clk,
  input  logic                  reset,
  wordle_guess_scorer_if.slave  bus
);

  localparam int WORD_W  = NUM_LETTERS * LETTER_W;
  localparam int SCORE_W = 2 * NUM_LETTERS;
  localparam int IDX_W   = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_LETTERS - 1);
  localparam logic [SCORE_W-1:0] ALL_GREEN = {NUM_LETTERS{2'b10}};

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [WORD_W-1:0]    guess_q, answer_q;
  logic [SCORE_W-1:0]   score_q;
  logic [NUM_LETTERS-1:0] used;
  logic                 win_q;
  logic                 force_clear;

  logic [LETTER_W-1:0]  g_cur, a_cur;
  logic [1:0]           s_cur;
  logic                 found;
  logic [IDX_W-1:0]     found_j;

  function automatic logic [LETTER_W-1:0] letter_of(input logic [WORD_W-1:0] w,
                                                    input int i);
    return w[(NUM_LETTERS-1-i)*LETTER_W +: LETTER_W];
  endfunction

  function automatic int score_pos(input logic [IDX_W-1:0] i);
    return SCORE_W - 2 - 2*int'(i);
  endfunction

  assign g_cur = letter_of(guess_q,  int'(idx));
  assign a_cur = letter_of(answer_q, int'(idx));
  assign s_cur = score_q[score_pos(idx) +: 2];

  // Lowest unused answer position holding the current guess letter; scanning
  // downward lets the last hit (the lowest j) win.
  always_comb begin
    found   = 1'b0;
    found_j = '0;
    for (int j = NUM_LETTERS-1; j >= 0; j--) begin
      if (!used[j] && (letter_of(answer_q, j) == g_cur)) begin
        found   = 1'b1;
        found_j = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)        state_nxt = GREEN;
      GREEN:   if (idx == LAST_IDX)  state_nxt = YELLOW;
      YELLOW:  if (idx == LAST_IDX)  state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      idx     <= '0;
      used    <= '0;
      score_q <= '0;
      win_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            guess_q  <= bus.guess;
            answer_q <= bus.answer;
            score_q  <= '0;
            used     <= '0;
            idx      <= '0;
          end
        end
        GREEN: begin
          if (g_cur == a_cur) begin
            score_q[score_pos(idx) +: 2] <= 2'b10;
            used[idx]                    <= 1'b1;
          end
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        YELLOW: begin
          if ((s_cur != 2'b10) && found) begin
            score_q[score_pos(idx) +: 2] <= 2'b01;
            used[found_j]                <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            idx <= '0;
            // Yellow never creates a green, so the pre-update score decides win.
            win_q <= !force_clear && (score_q == ALL_GREEN);
            if (force_clear) score_q <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WORDLE_SCORE_LETTER_CHECK_EN
  logic bad;
  logic err_q;

  function automatic logic guess_has_bad(input logic [WORD_W-1:0] w);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if ((letter_of(w, i) < LETTER_W'(8'h41)) || (letter_of(w, i) > LETTER_W'(8'h5A)))
        b = 1'b1;
    end
    return b;
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      bad   <= 1'b0;
      err_q <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      bad <= guess_has_bad(bus.guess);
    end else if ((state == YELLOW) && (idx == LAST_IDX)) begin
      err_q <= bad;
    end
  end

  assign force_clear = bad;
  assign bus.err     = err_q;
`else
  assign force_clear = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.score = score_q;
  assign bus.win   = win_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
module tb_wordle_guess_scorer;

`ifdef WORDLE_SCORE_LETTER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  wordle_guess_scorer_if #(.NUM_LETTERS(5), .LETTER_W(8)) bus ();

  wordle_guess_scorer #(.NUM_LETTERS(5), .LETTER_W(8)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [39:0] guess;
    logic [39:0] answer;
    logic [9:0]  score;   // expected score with no range checking
    logic        win;
    logic        bad;     // guess contains a letter outside 'A'..'Z'
  } vec_t;

  typedef struct {
    logic [9:0] score;
    logic       win;
    logic       err;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e.score = (CHK && v.bad) ? 10'h000 : v.score;
    e.win   = (CHK && v.bad) ? 1'b0 : v.win;
    e.err   = CHK && v.bad;
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge Clk) begin
    if (bus.done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_score", 32'(bus.score), 32'(e.score));
        check("done_win",   32'(bus.win),   32'(e.win));
        check("done_err",   32'(bus.err),   32'(e.err));
      end
    end
  end

  // Starts one scoring run (caller is at a negedge) and follows it to idle.
  task automatic run_one(input vec_t v, input string name);
    int   busy_cycles;
    int   done_k;
    int   k;
    exp_t e;
    e = expect_of(v);
    bus.guess  = v.guess;
    bus.answer = v.answer;
    bus.start  = 1'b1;
    sb.push_back(e);
    @(negedge Clk);
    bus.start  = 1'b0;
    check({name, "_score_cleared"}, 32'(bus.score), 32'd0);
    busy_cycles = 0;
    done_k = 0;
    k = 1;
    while (bus.busy && k < 40) begin
      if (bus.done && done_k == 0) done_k = k;
      busy_cycles++;
      k++;
      @(negedge Clk);
    end
    check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd11);
    check({name, "_done_cycle"},  32'(done_k),      32'd11);
    repeat (2) @(negedge Clk);
    check({name, "_score_hold"}, 32'(bus.score), 32'(e.score));
  endtask

  initial begin
    vec_t v;
    int   dc;

    vecs[0] = '{guess:"ROBOT", answer:"ROBOT", score:10'h2AA, win:1'b1, bad:1'b0};
    vecs[1] = '{guess:"BOOST", answer:"ROBOT", score:10'h192, win:1'b0, bad:1'b0};
    vecs[2] = '{guess:"BBBBB", answer:"ABBOT", score:10'h0A0, win:1'b0, bad:1'b0};
    vecs[3] = '{guess:"AB?DE", answer:"ABIDE", score:10'h28A, win:1'b0, bad:1'b1};
    vecs[4] = '{guess:"SPEED", answer:"ABIDE", score:10'h011, win:1'b0, bad:1'b0};
    vecs[5] = '{guess:"EERIE", answer:"THERE", score:10'h112, win:1'b0, bad:1'b0};
    vecs[6] = '{guess:"robot", answer:"ROBOT", score:10'h000, win:1'b0, bad:1'b1};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.guess  = '0;
    bus.answer = '0;
    repeat (3) @(negedge Clk);
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_done",  32'(bus.done),  32'd0);
    check("reset_score", 32'(bus.score), 32'd0);
    check("reset_win",   32'(bus.win),   32'd0);
    check("reset_err",   32'(bus.err),   32'd0);
    reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of the yellow pass (idx=2): abort, no done afterwards.
    bus.guess  = "BOOST";
    bus.answer = "ROBOT";
    bus.start  = 1'b1;
    @(negedge Clk);
    bus.start  = 1'b0;
    repeat (7) @(negedge Clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    check("abort_score_before_nonzero", 32'(bus.score != 10'h000), 32'd1);
    reset = 1'b1;
    dc = done_count;
    @(negedge Clk);
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_score", 32'(bus.score), 32'd0);
    check("abort_done",  32'(bus.done),  32'd0);
    reset = 1'b0;
    repeat (20) @(negedge Clk);
    check("abort_no_done", 32'(done_count), 32'(dc));

    // start re-pulsed at cycle 3 (with new words) and in the DONE cycle.
    v = vecs[1];
    bus.guess  = v.guess;
    bus.answer = v.answer;
    bus.start  = 1'b1;
    sb.push_back(expect_of(v));
    dc = done_count;
    @(negedge Clk);
    bus.start  = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    bus.start  = 1'b1;
    bus.guess  = "ZZZZZ";
    bus.answer = "QQQQQ";
    @(negedge Clk);
    bus.start  = 1'b0;
    repeat (7) @(negedge Clk);
    check("repulse_done_cycle", 32'(bus.done), 32'd1);
    bus.start  = 1'b1;
    @(negedge Clk);
    bus.start  = 1'b0;
    check("repulse_idle_after_done", 32'(bus.busy), 32'd0);
    repeat (15) @(negedge Clk);
    check("repulse_single_done", 32'(done_count), 32'(dc + 1));
    check("repulse_still_idle",  32'(bus.busy),   32'd0);
    check("repulse_score_hold",  32'(bus.score),  32'(expect_of(v).score));

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
